// File: rtl/fl_pkg.sv
// fl_pkg: shared states, timing defaults and beat slot placement for the flash stream reader
package fl_pkg;
  typedef enum logic [2:0] {IDLE, FLRST, RECOVER, ACCESS, CAPTURE, SEND} fl_state_t;
  localparam int FL_RST_CYCLES_DEF = 26;
  localparam int FL_RECOVER_CYCLES_DEF = 3;
  localparam int FL_ACCESS_CYCLES_DEF = 6;
  localparam int FL_FRAME_LAST_ADDR = 8294399;
  function automatic int fl_byte_pos(int slot, int lanes, int wb, bit swap);
    int lane;
    int nth;
    lane = slot / wb;
    nth = slot % wb;
    return (lanes - 1 - lane) * wb + (swap ? nth : wb - 1 - nth);
  endfunction
endpackage

// File: rtl/fl_beat_packer.sv
// fl_beat_packer: slot counter and byte insertion into the beat register; FL_BYTE_SWAP_EN selects little-endian words
module fl_beat_packer import fl_pkg::*; #(
  parameter int WORD_BYTES = 2,
  parameter int LANES = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          ins,
  input  logic                          tail,
  input  logic                          rewind,
  input  logic [7:0]                    din,
  output logic [LANES*WORD_BYTES*8-1:0] data,
  output logic                          full
);
  localparam int N = LANES * WORD_BYTES;
  localparam int KW = N > 1 ? $clog2(N) : 1;
`ifdef FL_BYTE_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif
  logic [KW-1:0] k;
  assign full = k == KW'(N - 1);
  // the final byte of a range also zeroes every slot after it
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      k <= '0;
      data <= '0;
    end else if (clr) begin
      k <= '0;
      data <= '0;
    end else begin
      if (rewind) k <= '0;
      else if (ins && !full) k <= k + 1'b1;
      for (int s = 0; s < N; s++)
        if (ins && s == int'(k)) data[fl_byte_pos(s, LANES, WORD_BYTES, SWAP)*8 +: 8] <= din;
        else if (ins && tail && s > int'(k)) data[fl_byte_pos(s, LANES, WORD_BYTES, SWAP)*8 +: 8] <= 8'h00;
    end
endmodule

// File: rtl/fl_stream_reader.sv
// fl_stream_reader: flash reset/recovery then ranged byte streaming packed into valid/ack beats; FL_BYTE_SWAP_EN swaps bytes within words
module fl_stream_reader import fl_pkg::*; #(
  parameter int ADDR_W = 23,
  parameter int WORD_BYTES = 2,
  parameter int LANES = 2,
  parameter int RST_CYCLES = FL_RST_CYCLES_DEF,
  parameter int RECOVER_CYCLES = FL_RECOVER_CYCLES_DEF,
  parameter int ACCESS_CYCLES = FL_ACCESS_CYCLES_DEF
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             start_addr,
  input  logic [ADDR_W-1:0]             end_addr,
  input  logic                          abort,
  input  logic                          out_ack,
  input  logic [7:0]                    FL_DQ,
  output logic [ADDR_W-1:0]             FL_ADDR,
  output logic                          FL_CE_N,
  output logic                          FL_OE_N,
  output logic                          FL_WE_N,
  output logic                          FL_RST_N,
  output logic [LANES*WORD_BYTES*8-1:0] out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          busy,
  output logic                          finished,
  output logic                          cfg_err
);
  // a one-cycle access has no wait phase, so byte fetches go straight to CAPTURE
  localparam fl_state_t ENTRY = fl_state_t'((ACCESS_CYCLES > 1) ? ACCESS : CAPTURE);
  fl_state_t state, nxt;
  logic [31:0] cnt;
  logic [ADDR_W-1:0] start_a, end_a;
  logic last_q, fin_q, err_q;
  logic kill, go, bad, ld, inc, ins, tail, rew, done, full;
  assign kill = abort && state != IDLE;
  assign FL_CE_N = !(state == ACCESS || state == CAPTURE || state == SEND);
  assign FL_OE_N = FL_CE_N;
  assign FL_WE_N = 1'b1;
  assign FL_RST_N = state != FLRST;
  assign out_valid = state == SEND;
  assign out_last = last_q;
  assign busy = state != IDLE;
  assign finished = fin_q;
  assign cfg_err = err_q;
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    go = 1'b0;
    bad = 1'b0;
    ld = 1'b0;
    inc = 1'b0;
    ins = 1'b0;
    tail = 1'b0;
    rew = 1'b0;
    done = 1'b0;
    if (kill) nxt = IDLE;
    else case (state)
      IDLE: if (start) begin
        bad = start_addr > end_addr;
        go = !bad;
        nxt = bad ? IDLE : FLRST;
      end
      FLRST: nxt = (cnt == 32'(RST_CYCLES - 1)) ? RECOVER : FLRST;
      RECOVER: begin
        ld = cnt == 32'(RECOVER_CYCLES - 1);
        nxt = ld ? ENTRY : RECOVER;
      end
      ACCESS: nxt = (cnt == 32'(ACCESS_CYCLES - 2)) ? CAPTURE : ACCESS;
      CAPTURE: begin
        ins = 1'b1;
        tail = FL_ADDR == end_a;
        inc = !tail;
        nxt = (tail || full) ? SEND : ENTRY;
      end
      SEND: if (out_ack) begin
        done = last_q;
        rew = !last_q;
        nxt = last_q ? IDLE : ENTRY;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      FL_ADDR <= '0;
      start_a <= '0;
      end_a <= '0;
      last_q <= 1'b0;
      fin_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt <= (nxt != state) ? '0 : cnt + 32'd1;
      err_q <= bad;
      if (go) begin
        start_a <= start_addr;
        end_a <= end_addr;
      end
      if (ld) FL_ADDR <= start_a;
      else if (inc) FL_ADDR <= FL_ADDR + 1'b1;
      last_q <= (kill || done || go) ? 1'b0 : tail ? 1'b1 : last_q;
      fin_q <= (kill || go) ? 1'b0 : done ? 1'b1 : fin_q;
    end
  fl_beat_packer #(.WORD_BYTES(WORD_BYTES), .LANES(LANES)) u_pack (
    .CLOCK_50(CLOCK_50),
    .rst_n(rst_n),
    .clr(go),
    .ins(ins),
    .tail(tail),
    .rewind(rew),
    .din(FL_DQ),
    .data(out_data),
    .full(full)
  );
endmodule

// File: tb/tb_fl_stream_reader.sv
// tb_fl_stream_reader: directed and randomized ranges checked against a byte-list beat model
module tb_fl_stream_reader;
  logic CLOCK_50 = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ack = 1'b0;
  logic [22:0] start_addr = '0;
  logic [22:0] end_addr = '0;
  logic [7:0] key = 8'h00;
  logic [7:0] FL_DQ;
  logic [22:0] FL_ADDR;
  logic FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N;
  logic [31:0] out_data;
  logic out_valid, out_last, busy, finished, cfg_err;
  int checks = 0;
  int failures = 0;

  always #10 CLOCK_50 = ~CLOCK_50;
  assign FL_DQ = FL_ADDR[7:0] ^ key;

  fl_stream_reader dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .abort(abort), .out_ack(out_ack), .FL_DQ(FL_DQ),
    .FL_ADDR(FL_ADDR), .FL_CE_N(FL_CE_N), .FL_OE_N(FL_OE_N), .FL_WE_N(FL_WE_N),
    .FL_RST_N(FL_RST_N), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .finished(finished), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // beat = four consecutive flash bytes; word 0 high, bytes MSB-first (or LSB-first when swapped)
  function automatic logic [31:0] beat_val(input int base, input int last, input logic [7:0] k);
    logic [31:0] r;
    int a, word, nth, p;
    logic [7:0] b;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      a = base + j;
      b = (a <= last) ? (8'(a) ^ k) : 8'h00;
      word = j / 2;
      nth = j % 2;
`ifdef FL_BYTE_SWAP_EN
      p = nth;
`else
      p = 1 - nth;
`endif
      r[((1 - word) * 2 + p) * 8 +: 8] = b;
    end
    return r;
  endfunction

  task automatic check_reset(input string p);
    chk({p, "_addr"}, 64'(FL_ADDR), 0);
    chk({p, "_ce"}, 64'(FL_CE_N), 1);
    chk({p, "_oe"}, 64'(FL_OE_N), 1);
    chk({p, "_we"}, 64'(FL_WE_N), 1);
    chk({p, "_rstn"}, 64'(FL_RST_N), 1);
    chk({p, "_data"}, 64'(out_data), 0);
    chk({p, "_valid"}, 64'(out_valid), 0);
    chk({p, "_last"}, 64'(out_last), 0);
    chk({p, "_busy"}, 64'(busy), 0);
    chk({p, "_finished"}, 64'(finished), 0);
    chk({p, "_cfgerr"}, 64'(cfg_err), 0);
  endtask

  task automatic begin_xfer(input int s, input int e);
    @(negedge CLOCK_50);
    start_addr = 23'(s);
    end_addr = 23'(e);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  // mode 0: ack always high; 1: random ack; 2: withhold ack 10 cycles on the first beat
  task automatic xfer(input int s, input int e, input int mode, input bit poke);
    logic [31:0] q[$];
    logic [31:0] held;
    int cyc, rstlow, tce, tv, hold, bbase, nb1, extra;
    bit got, holding, a;
    cyc = 0; rstlow = 0; tce = -1; tv = -1; hold = 0; bbase = s; extra = 0;
    got = 0; holding = 0; held = '0;
    nb1 = (e - s + 1 < 4) ? e - s + 1 : 4;
    for (int b = s; b <= e; b += 4) q.push_back(beat_val(b, e, key));
    out_ack = 1'b1;
    begin_xfer(s, e);
    while (!got && cyc < 5000) begin
      if (poke) begin
        start = cyc == 3;
        if (cyc == 3) begin
          start_addr = 23'(e + 17);
          end_addr = 23'(e + 40);
        end
      end
      if (!FL_RST_N) rstlow++;
      if (!FL_CE_N && tce < 0) tce = cyc;
      if (out_valid) begin
        if (tv < 0) tv = cyc;
        if (q.size() == 0) begin
          chk("extra_beat", 1, 0);
          got = 1;
        end else begin
          if (!holding) begin
            chk("beat_data", 64'(out_data), 64'(q[0]));
            chk("beat_last", 64'(out_last), 64'(q.size() == 1));
            held = out_data;
            holding = 1;
          end else chk("hold_stable", 64'(out_data), 64'(held));
          chk("send_addr", 64'(FL_ADDR), (q.size() == 1) ? 64'(e) : 64'(bbase + 4));
          a = (mode == 1) ? 1'($urandom_range(0, 1)) : !(mode == 2 && bbase == s && hold < 10);
          if (!a) hold++;
          out_ack = a;
          if (a) begin
            void'(q.pop_front());
            holding = 0;
            bbase += 4;
            if (q.size() == 0) got = 1;
          end
        end
      end else out_ack = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLOCK_50);
      cyc++;
    end
    out_ack = 1'b0;
    start = 1'b0;
    chk("xfer_done", 64'(got), 1);
    chk("beats_left", 64'(q.size()), 0);
    chk("finished", 64'(finished), 1);
    chk("busy_after", 64'(busy), 0);
    chk("ce_after", 64'(FL_CE_N), 1);
    chk("rst_len", 64'(rstlow), 26);
    chk("latency", 64'(tv - tce), 64'(nb1 * 6));
    if (mode == 2) chk("withheld", 64'(hold), 10);
    repeat (4) begin
      @(negedge CLOCK_50);
      extra += int'(out_valid);
    end
    chk("no_extra", 64'(extra), 0);
  endtask

  initial begin
    int n, s, e;
    #5 check_reset("por");
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50);
    xfer(0, 7, 0, 0);
    xfer(5, 5, 0, 0);
    xfer(0, 7, 2, 0);
    xfer(0, 3, 0, 0);
    // rejected range: finished from the last run must survive
    @(negedge CLOCK_50);
    start_addr = 23'd9;
    end_addr = 23'd3;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk("cfg_err_pulse", 64'(cfg_err), 1);
    chk("cfg_busy", 64'(busy), 0);
    chk("cfg_finished", 64'(finished), 1);
    @(negedge CLOCK_50);
    chk("cfg_err_drop", 64'(cfg_err), 0);
    chk("cfg_busy2", 64'(busy), 0);
    key = 8'h5a;
    xfer(100, 110, 0, 1);
    // abort with ack in SEND
    begin_xfer(0, 7);
    n = 0;
    while (!out_valid && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("wait_send", 64'(out_valid), 1);
    abort = 1'b1;
    out_ack = 1'b1;
    @(negedge CLOCK_50);
    abort = 1'b0;
    out_ack = 1'b0;
    chk("abs_valid", 64'(out_valid), 0);
    chk("abs_last", 64'(out_last), 0);
    chk("abs_busy", 64'(busy), 0);
    chk("abs_finished", 64'(finished), 0);
    chk("abs_ce", 64'(FL_CE_N), 1);
    chk("abs_oe", 64'(FL_OE_N), 1);
    // abort in ACCESS
    begin_xfer(0, 7);
    n = 0;
    while (FL_CE_N && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("wait_access", 64'(FL_CE_N), 0);
    abort = 1'b1;
    @(negedge CLOCK_50);
    abort = 1'b0;
    chk("aba_busy", 64'(busy), 0);
    chk("aba_ce", 64'(FL_CE_N), 1);
    chk("aba_rstn", 64'(FL_RST_N), 1);
    chk("aba_valid", 64'(out_valid), 0);
    chk("aba_finished", 64'(finished), 0);
    xfer(3, 12, 1, 0);
    repeat (6) begin
      key = 8'($urandom);
      s = int'($urandom_range(0, 4000));
      e = s + int'($urandom_range(0, 17));
      xfer(s, e, 1, 0);
    end
    // asynchronous reset while streaming
    begin_xfer(64, 96);
    n = 0;
    while (FL_CE_N && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("wait_access2", 64'(FL_CE_N), 0);
    repeat (10) @(negedge CLOCK_50);
    #3 rst_n = 1'b0;
    #2 check_reset("arst");
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
